// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline.
// It keeps a per-register write scoreboard and generates the freeze, flush and stall-cycle count.
module pipe_hazard_ctrl #(
    parameter int unsigned NREG  = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic             id_valid,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic [3:0]       id_dest,
    input  logic             id_cond_ok,
    input  logic             exe_branch_taken,
    input  logic             mem_busy,
    output logic             hazard,
    output logic             freeze,
    output logic             flush,
    output logic [NREG-1:0]  pending,
    output logic [CNT_W-1:0] stall_count
);

    logic [NREG-1:0][1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]     stall_count_q, stall_count_d;
    logic [1:0]           load_val;
    logic                 issue;

    always_comb begin
        pending = '0;
        for (int r = 0; r < NREG; r++) begin
            pending[r] = (cnt_q[r] != 2'd0);
        end
    end

    assign freeze = mem_busy;
    assign flush  = exe_branch_taken & ~freeze;
    // Uses the ungated controller flags so hazard never feeds back on itself.
    assign hazard = id_valid & ~flush &
                    (pending[id_src1] | (id_two_src & pending[id_src2]));
    assign issue  = id_valid & id_cond_ok & id_wb_en & ~hazard & ~freeze & ~flush;

    // Cycles until the result is readable by ID; fwd_en only matters at issue.
    always_comb begin
        load_val = 2'd0;
        if (!fwd_en) begin
            load_val = 2'd2;
        end else if (id_mem_r_en) begin
            load_val = 2'd1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int r = 0; r < NREG; r++) begin
            if (!freeze && cnt_q[r] != 2'd0) begin
                cnt_d[r] = cnt_q[r] - 2'd1;
            end
            // A new writer overrides the decrement of an older one to the same register.
            if (issue && id_dest == 4'(r)) begin
                cnt_d[r] = load_val;
            end
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if ((hazard || freeze) && stall_count_q != '1) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed hazard/flush/freeze/pending/stall values.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fwd_en;
    logic        id_valid;
    logic [3:0]  id_src1;
    logic [3:0]  id_src2;
    logic        id_two_src;
    logic        id_wb_en;
    logic        id_mem_r_en;
    logic [3:0]  id_dest;
    logic        id_cond_ok;
    logic        exe_branch_taken;
    logic        mem_busy;
    logic        hazard;
    logic        freeze;
    logic        flush;
    logic [15:0] pending;
    logic [15:0] stall_count;

    int vectors = 0;
    int miscompares = 0;

    pipe_hazard_ctrl #(
        .NREG (16),
        .CNT_W(16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fwd_en          (fwd_en),
        .id_valid        (id_valid),
        .id_src1         (id_src1),
        .id_src2         (id_src2),
        .id_two_src      (id_two_src),
        .id_wb_en        (id_wb_en),
        .id_mem_r_en     (id_mem_r_en),
        .id_dest         (id_dest),
        .id_cond_ok      (id_cond_ok),
        .exe_branch_taken(exe_branch_taken),
        .mem_busy        (mem_busy),
        .hazard          (hazard),
        .freeze          (freeze),
        .flush           (flush),
        .pending         (pending),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                          input logic two, input logic wb, input logic mr,
                          input logic [3:0] d, input logic cok);
        id_valid    = v;
        id_src1     = s1;
        id_src2     = s2;
        id_two_src  = two;
        id_wb_en    = wb;
        id_mem_r_en = mr;
        id_dest     = d;
        id_cond_ok  = cok;
        #1;
    endtask

    task automatic idle();
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    endtask

    initial begin
        rst = 1'b0;
        fwd_en = 1'b0;
        exe_branch_taken = 1'b0;
        mem_busy = 1'b0;
        idle();
        #2;
        chk("reset_pending", 32'(pending), 32'h0);
        chk("reset_stall", 32'(stall_count), 32'h0);
        chk("reset_hazard", 32'(hazard), 32'h0);
        chk("reset_flush", 32'(flush), 32'h0);
        chk("reset_freeze", 32'(freeze), 32'h0);
        rst = 1'b1;
        tick();

        // No-forward RAW: ADD R1 then SUB R2,R1,R3
        fwd_en = 1'b0;
        set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1);
        chk("nf_producer_hazard", 32'(hazard), 32'h0);
        tick();
        set_id(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1);
        chk("nf_t1_hazard", 32'(hazard), 32'h1);
        chk("nf_t1_pending", 32'(pending), 32'h0002);
        tick();
        chk("nf_t2_hazard", 32'(hazard), 32'h1);
        chk("nf_t2_pending", 32'(pending), 32'h0002);
        tick();
        chk("nf_t3_hazard", 32'(hazard), 32'h0);
        chk("nf_t3_pending", 32'(pending), 32'h0);
        chk("nf_stall", 32'(stall_count), 32'd2);
        tick();
        idle();
        chk("nf_sub_pending", 32'(pending), 32'h0004);
        tick();
        tick();
        chk("nf_drained", 32'(pending), 32'h0);

        // Forwarding: LDR R4 then ADD R5,R4,R4, then ALU consumer of R5
        fwd_en = 1'b1;
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd4, 1'b1);
        tick();
        set_id(1'b1, 4'd4, 4'd4, 1'b1, 1'b1, 1'b0, 4'd5, 1'b1);
        chk("fl_t1_hazard", 32'(hazard), 32'h1);
        chk("fl_t1_pending", 32'(pending), 32'h0010);
        tick();
        chk("fl_t2_hazard", 32'(hazard), 32'h0);
        tick();
        set_id(1'b1, 4'd5, 4'd0, 1'b0, 1'b1, 1'b0, 4'd6, 1'b1);
        chk("fa_hazard", 32'(hazard), 32'h0);
        chk("fa_pending", 32'(pending), 32'h0);
        tick();
        idle();
        chk("fa_pending_after", 32'(pending), 32'h0);
        chk("fwd_stall", 32'(stall_count), 32'd3);

        // Freeze: LDR R6 (no forwarding), consumer ADD R9,R6 waits through 3 freeze cycles
        fwd_en = 1'b0;
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd6, 1'b1);
        tick();
        mem_busy = 1'b1;
        set_id(1'b1, 4'd6, 4'd0, 1'b0, 1'b1, 1'b0, 4'd9, 1'b1);
        chk("fz_freeze", 32'(freeze), 32'h1);
        chk("fz_hazard", 32'(hazard), 32'h1);
        tick();
        tick();
        chk("fz_pending_hold", 32'(pending), 32'h0040);
        tick();
        mem_busy = 1'b0;
        #1;
        chk("fz_released", 32'(freeze), 32'h0);
        chk("fz_stall_freeze", 32'(stall_count), 32'd6);
        chk("fz_hazard_after1", 32'(hazard), 32'h1);
        tick();
        chk("fz_hazard_after2", 32'(hazard), 32'h1);
        chk("fz_pending_after2", 32'(pending), 32'h0040);
        tick();
        chk("fz_hazard_clear", 32'(hazard), 32'h0);
        chk("fz_stall_total", 32'(stall_count), 32'd8);
        tick();
        idle();
        chk("fz_r9_pending", 32'(pending), 32'h0200);
        tick();
        tick();

        // Branch flush: MOV R7 in ID squashed; then same under mem_busy
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd7, 1'b1);
        exe_branch_taken = 1'b1;
        #1;
        chk("br_flush", 32'(flush), 32'h1);
        tick();
        exe_branch_taken = 1'b0;
        idle();
        chk("br_pending7", 32'(pending), 32'h0);
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd7, 1'b1);
        exe_branch_taken = 1'b1;
        mem_busy = 1'b1;
        #1;
        chk("br_busy_flush", 32'(flush), 32'h0);
        tick();
        mem_busy = 1'b0;
        #1;
        chk("br_late_flush", 32'(flush), 32'h1);
        tick();
        exe_branch_taken = 1'b0;
        idle();
        chk("br_late_pending", 32'(pending), 32'h0);
        chk("br_stall", 32'(stall_count), 32'd9);

        // Reissue collision on R8, then STR R8 with and without a real second source
        set_id(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd8, 1'b1);
        tick();
        idle();
        tick();
        chk("rc_cnt1_pending", 32'(pending), 32'h0100);
        set_id(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd8, 1'b1);
        tick();
        set_id(1'b1, 4'd0, 4'd8, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("rc_reload_pending", 32'(pending), 32'h0100);
        chk("str_one_src_hazard", 32'(hazard), 32'h0);
        id_two_src = 1'b1;
        #1;
        chk("str_two_src_hazard", 32'(hazard), 32'h1);
        tick();
        chk("str_hazard_2nd", 32'(hazard), 32'h1);
        tick();
        chk("str_hazard_clear", 32'(hazard), 32'h0);
        chk("rc_stall", 32'(stall_count), 32'd11);
        tick();
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd10, 1'b0);
        tick();
        idle();
        chk("cond_fail_pending", 32'(pending), 32'h0);

        // Asynchronous reset mid-stall with R1 and R2 outstanding
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1);
        tick();
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1);
        tick();
        set_id(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1);
        chk("ar_pending_before", 32'(pending), 32'h0006);
        chk("ar_hazard_before", 32'(hazard), 32'h1);
        rst = 1'b0;
        #1;
        chk("ar_pending_now", 32'(pending), 32'h0);
        chk("ar_stall_now", 32'(stall_count), 32'h0);
        rst = 1'b1;
        #1;
        chk("ar_hazard_release", 32'(hazard), 32'h0);
        tick();
        chk("ar_stall_after", 32'(stall_count), 32'h0);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
